// File: rtl/problem2_checker.sv
// rtl/problem2_checker.sv - checks a one-cycle register stage (b <= a, c = b) over a timed run
module problem2_checker #(
   parameter int WARMUP      = 2,
   parameter int NCHECK      = 8,
   parameter int HALT_ON_ERR = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_b_cnt,
   output logic [CNT_W-1:0] err_c_cnt,
   output logic [CNT_W-1:0] first_err_idx
);

   typedef enum logic [1:0] {IDLE, WARM, CHECK, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t      state;
   state_t      state_nx;
   logic        a_q;
   logic [7:0]  warm_cnt;
   logic [15:0] chk_idx;
   logic        launch;
   logic        chk_en;
   logic        bad_b;
   logic        bad_c;
   logic        chk_fail;
   logic        last_chk;

   // Delayed copy of a: the value b must hold at the next edge.
   always_ff @(posedge clk) begin
      if (rst) a_q <= 1'b0;
      else     a_q <= a;
   end

   // State register; reset wins over any start on the same edge.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode plus the per-cycle check verdict.
   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      chk_en   = 1'b0;
      // Case-equality so an x or z on either side is reported as a mismatch.
      bad_b    = (b !== a_q);
      bad_c    = (c !== b);
      chk_fail = bad_b | bad_c;
      last_chk = (chk_idx == 16'(NCHECK - 1));
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch   = 1'b1;
               state_nx = WARM;
            end
         end
         WARM: begin
            if (warm_cnt == 8'd0) state_nx = CHECK;
         end
         CHECK: begin
            chk_en = 1'b1;
            if (last_chk || ((HALT_ON_ERR != 0) && chk_fail)) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Run counters: cleared on launch, updated once per check, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         warm_cnt      <= 8'd0;
         chk_idx       <= 16'd0;
         fail          <= 1'b0;
         pass_cnt      <= '0;
         err_b_cnt     <= '0;
         err_c_cnt     <= '0;
         first_err_idx <= CNT_MAX;
      end else if (launch) begin
         warm_cnt      <= 8'(WARMUP - 1);
         chk_idx       <= 16'd0;
         fail          <= 1'b0;
         pass_cnt      <= '0;
         err_b_cnt     <= '0;
         err_c_cnt     <= '0;
         first_err_idx <= CNT_MAX;
      end else begin
         if ((state == WARM) && (warm_cnt != 8'd0)) warm_cnt <= warm_cnt - 8'd1;
         if (chk_en) begin
            chk_idx <= chk_idx + 16'd1;
            if (!chk_fail && (pass_cnt != CNT_MAX))  pass_cnt  <= pass_cnt + CNT_W'(1);
            if (bad_b && (err_b_cnt != CNT_MAX))     err_b_cnt <= err_b_cnt + CNT_W'(1);
            if (bad_c && (err_c_cnt != CNT_MAX))     err_c_cnt <= err_c_cnt + CNT_W'(1);
            // Only the first failure of a run records its index.
            if (chk_fail && !fail) begin
               fail          <= 1'b1;
               first_err_idx <= CNT_W'(chk_idx);
            end
         end
      end
   end

   assign busy = (state == WARM) || (state == CHECK);
   assign done = (state == DONE);

endmodule

// File: tb/tb_problem2_checker.sv
// tb/tb_problem2_checker.sv - directed self-checking bench for problem2_checker
module tb_problem2_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a = 1'b0;
   logic b = 1'b0;
   logic c = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic        busy0, done0, fail0;
   logic [15:0] pass0, errb0, errc0, idx0;
   logic        busy1, done1, fail1;
   logic [15:0] pass1, errb1, errc1, idx1;
   logic        busy2, done2, fail2;
   logic [1:0]  pass2, errb2, errc2, idx2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   problem2_checker dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .c(c),
      .busy(busy0), .done(done0), .fail(fail0), .pass_cnt(pass0),
      .err_b_cnt(errb0), .err_c_cnt(errc0), .first_err_idx(idx0)
   );

   problem2_checker #(.HALT_ON_ERR(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .c(c),
      .busy(busy1), .done(done1), .fail(fail1), .pass_cnt(pass1),
      .err_b_cnt(errb1), .err_c_cnt(errc1), .first_err_idx(idx1)
   );

   problem2_checker #(.NCHECK(6), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .c(c),
      .busy(busy2), .done(done2), .fail(fail2), .pass_cnt(pass2),
      .err_b_cnt(errb2), .err_c_cnt(errc2), .first_err_idx(idx2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: model an ideal stage (b = a of previous edge, c = b), optionally corrupted.
   task automatic cyc(input logic [2:0] st, input bit bb, input bit bc, input bit r);
      logic bexp;
      bexp = a;
      b = bb ? ~bexp : bexp;
      c = bc ? ~b : b;
      a = ~a;
      {start2, start1, start0} = st;
      rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      cyc(3'b000, 0, 0, 1);
      cyc(3'b000, 0, 0, 1);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_fail", 32'(fail0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_errb", 32'(errb0), 32'd0);
      chk("rst_errc", 32'(errc0), 32'd0);
      chk("rst_idx",  32'(idx0),  32'hFFFF);

      // Ideal run with defaults.
      cyc(3'b001, 0, 0, 0);
      chk("t1_busy_start", 32'(busy0), 32'd1);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         chk("t1_not_done", 32'(done0), 32'd0);
         cyc(3'b000, 0, 0, 0);
      end
      chk("t1_done", 32'(done0), 32'd1);
      chk("t1_busy", 32'(busy0), 32'd0);
      chk("t1_pass", 32'(pass0), 32'd8);
      chk("t1_errb", 32'(errb0), 32'd0);
      chk("t1_errc", 32'(errc0), 32'd0);
      chk("t1_fail", 32'(fail0), 32'd0);
      chk("t1_idx",  32'(idx0),  32'hFFFF);
      cyc(3'b000, 1, 1, 0);
      chk("t1_hold_pass", 32'(pass0), 32'd8);
      chk("t1_hold_done", 32'(done0), 32'd1);

      // Restart from DONE; c lags b on check 3.
      cyc(3'b001, 0, 0, 0);
      chk("t2_clr_pass", 32'(pass0), 32'd0);
      chk("t2_clr_done", 32'(done0), 32'd0);
      chk("t2_busy",     32'(busy0), 32'd1);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(3'b000, 0, (i == 3), 0);
      chk("t2_done", 32'(done0), 32'd1);
      chk("t2_errc", 32'(errc0), 32'd1);
      chk("t2_errb", 32'(errb0), 32'd0);
      chk("t2_pass", 32'(pass0), 32'd7);
      chk("t2_fail", 32'(fail0), 32'd1);
      chk("t2_idx",  32'(idx0),  32'd3);

      // b wrong on every check, c follows b.
      cyc(3'b001, 0, 0, 0);
      chk("t3_clr_fail", 32'(fail0), 32'd0);
      chk("t3_clr_idx",  32'(idx0),  32'hFFFF);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(3'b000, 1, 0, 0);
      chk("t3_errb", 32'(errb0), 32'd8);
      chk("t3_errc", 32'(errc0), 32'd0);
      chk("t3_pass", 32'(pass0), 32'd0);
      chk("t3_fail", 32'(fail0), 32'd1);
      chk("t3_idx",  32'(idx0),  32'd0);

      // Halt on first error: b inverted from check 2.
      cyc(3'b010, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(3'b000, (i >= 2), 0, 0);
      chk("t4_done", 32'(done1), 32'd1);
      chk("t4_pass", 32'(pass1), 32'd2);
      chk("t4_errb", 32'(errb1), 32'd1);
      chk("t4_idx",  32'(idx1),  32'd2);
      chk("t4_fail", 32'(fail1), 32'd1);
      cyc(3'b000, 1, 0, 0);
      chk("t4_hold_errb", 32'(errb1), 32'd1);
      chk("t4_hold_done", 32'(done1), 32'd1);

      // Reset mid-run with start on the same edge.
      cyc(3'b001, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(3'b000, (i == 1), 0, 0);
      chk("t5_pre_pass", 32'(pass0), 32'd3);
      chk("t5_pre_idx",  32'(idx0),  32'd1);
      chk("t5_pre_busy", 32'(busy0), 32'd1);
      cyc(3'b001, 0, 0, 1);
      chk("t5_busy", 32'(busy0), 32'd0);
      chk("t5_done", 32'(done0), 32'd0);
      chk("t5_pass", 32'(pass0), 32'd0);
      chk("t5_errb", 32'(errb0), 32'd0);
      chk("t5_fail", 32'(fail0), 32'd0);
      chk("t5_idx",  32'(idx0),  32'hFFFF);
      for (int i = 0; i < 5; i++) cyc(3'b000, 0, 0, 0);
      chk("t5_idle_busy", 32'(busy0), 32'd0);
      cyc(3'b001, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(3'b000, 0, 0, 0);
      chk("t5_rerun_done", 32'(done0), 32'd1);
      chk("t5_rerun_pass", 32'(pass0), 32'd8);

      // Narrow counters saturate; start mid-run ignored; start in DONE restarts.
      cyc(3'b100, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      cyc(3'b000, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc((i == 1) ? 3'b100 : 3'b000, 0, 0, 0);
         if (i == 1) begin
            chk("t6_ign_pass", 32'(pass2), 32'd2);
            chk("t6_ign_busy", 32'(busy2), 32'd1);
         end
      end
      chk("t6_done", 32'(done2), 32'd1);
      chk("t6_pass", 32'(pass2), 32'd3);
      chk("t6_errb", 32'(errb2), 32'd0);
      chk("t6_fail", 32'(fail2), 32'd0);
      chk("t6_idx",  32'(idx2),  32'd3);
      cyc(3'b100, 0, 0, 0);
      chk("t6_rs_busy", 32'(busy2), 32'd1);
      chk("t6_rs_done", 32'(done2), 32'd0);
      chk("t6_rs_pass", 32'(pass2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
